// File: rtl/fp_add_sub_pipe.sv
// Five-stage IEEE-754 add/sub with valid/ready flow control,
// RNE/RTZ rounding, flush-to-zero subnormals and exception flags.
module fp_add_sub_pipe #(
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23,
    parameter int TAG_BITS  = 4,
    localparam int WIDTH    = 1 + EXP_BITS + MANT_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                operation_select,
    input  logic                rnd_mode,
    input  logic [TAG_BITS-1:0] in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    R,
    output logic [3:0]          flags,
    output logic [TAG_BITS-1:0] out_tag
);
    localparam int E   = EXP_BITS;
    localparam int M   = MANT_BITS;
    localparam int W   = WIDTH;
    localparam int T   = TAG_BITS;
    localparam int L   = M + 4;
    localparam int LZW = $clog2(L + 1);
    localparam int EW  = (E > LZW ? E : LZW) + 2;
    localparam logic [W-1:0]  QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
    localparam logic [EW-1:0] EMAX = EW'((1 << E) - 1);

    typedef struct packed {
        logic         spec;
        logic [W-1:0] sres;
        logic         snv;
        logic         rtz;
        logic [T-1:0] tag;
    } ctl_t;

    typedef struct packed {
        ctl_t         c;
        logic         sx;
        logic         sub;
        logic [E-1:0] ex;
        logic [E-1:0] ey;
        logic [M:0]   mx;
        logic [M:0]   my;
    } s1_t;

    typedef struct packed {
        ctl_t         c;
        logic         sx;
        logic         sub;
        logic [E-1:0] ex;
        logic [L-1:0] xa;
        logic [L-1:0] ya;
    } s2_t;

    typedef struct packed {
        ctl_t         c;
        logic         sx;
        logic [E-1:0] ex;
        logic [L:0]   sum;
    } s3_t;

    typedef struct packed {
        ctl_t          c;
        logic          sx;
        logic          zero;
        logic [EW-1:0] e;
        logic [L-1:0]  n;
    } s4_t;

    function automatic logic [LZW-1:0] lzc(input logic [L-1:0] v);
        logic [LZW-1:0] c;
        c = LZW'(L);
        for (int i = 0; i < L; i++) begin
            if (v[i]) c = LZW'(L - 1 - i);
        end
        return c;
    endfunction

    logic stall, adv;
    logic v1, v2, v3, v4;
    s1_t  st1, n1;
    s2_t  st2, n2;
    s3_t  st3, n3;
    s4_t  st4, n4;

    assign stall    = out_valid && !out_ready;
    assign adv      = !stall;
    assign in_ready = rst || !stall;

    // S1: classify, resolve special operands, order by magnitude
    logic [E-1:0] ea, eb;
    logic [M-1:0] fa, fb;
    logic         za, zb, ia, ib, na, nb, sbe, a_ge;

    always_comb begin
        ea   = a[W-2:M];
        eb   = b[W-2:M];
        fa   = a[M-1:0];
        fb   = b[M-1:0];
        za   = (ea == '0);
        zb   = (eb == '0);
        ia   = (ea == '1) && (fa == '0);
        ib   = (eb == '1) && (fb == '0);
        na   = (ea == '1) && (fa != '0);
        nb   = (eb == '1) && (fb != '0);
        sbe  = b[W-1] ^ operation_select;
        a_ge = a[W-2:0] >= b[W-2:0];
        n1          = '0;
        n1.c.rtz    = rnd_mode;
        n1.c.tag    = in_tag;
        n1.c.spec   = 1'b1;
        n1.sub      = a[W-1] ^ sbe;
        n1.sx       = a_ge ? a[W-1] : sbe;
        n1.ex       = a_ge ? ea : eb;
        n1.ey       = a_ge ? eb : ea;
        n1.mx       = a_ge ? {1'b1, fa} : {1'b1, fb};
        n1.my       = a_ge ? {1'b1, fb} : {1'b1, fa};
        if (na || nb) begin
            n1.c.sres = QNAN;
            n1.c.snv  = (na && !fa[M-1]) || (nb && !fb[M-1]);
        end else if (ia && ib && n1.sub) begin
            n1.c.sres = QNAN;
            n1.c.snv  = 1'b1;
        end else if (ia) begin
            n1.c.sres = a;
        end else if (ib) begin
            n1.c.sres = {sbe, b[W-2:0]};
        end else if (za && zb) begin
            n1.c.sres = {a[W-1] & sbe, {(W-1){1'b0}}};
        end else if (zb) begin
            n1.c.sres = a;
        end else if (za) begin
            n1.c.sres = {sbe, b[W-2:0]};
        end else begin
            n1.c.spec = 1'b0;
        end
    end

    // S2: align the smaller operand, folding lost bits into sticky
    logic [E-1:0]   diff;
    logic [2*L-1:0] wide;

    always_comb begin
        diff   = st1.ex - st1.ey;
        wide   = {st1.my, 3'b000, {L{1'b0}}} >> diff;
        n2     = '0;
        n2.c   = st1.c;
        n2.sx  = st1.sx;
        n2.sub = st1.sub;
        n2.ex  = st1.ex;
        n2.xa  = {st1.mx, 3'b000};
        if (32'(diff) >= 32'(M + 3)) begin
            n2.ya = {{(L-1){1'b0}}, 1'b1};
        end else begin
            n2.ya = {wide[2*L-1:L+1], wide[L] | (|wide[L-1:0])};
        end
    end

    // S3: magnitude add/subtract
    always_comb begin
        n3     = '0;
        n3.c   = st2.c;
        n3.sx  = st2.sx;
        n3.ex  = st2.ex;
        n3.sum = st2.sub ? ({1'b0, st2.xa} - {1'b0, st2.ya})
                         : ({1'b0, st2.xa} + {1'b0, st2.ya});
    end

    // S4: normalize
    logic [LZW-1:0] lz;

    always_comb begin
        lz      = lzc(st3.sum[L-1:0]);
        n4      = '0;
        n4.c    = st3.c;
        n4.sx   = st3.sx;
        n4.zero = (st3.sum == '0);
        if (st3.sum[L]) begin
            n4.n = {st3.sum[L:2], st3.sum[1] | st3.sum[0]};
            n4.e = {{(EW-E){1'b0}}, st3.ex} + EW'(1);
        end else begin
            n4.n = st3.sum[L-1:0] << lz;
            n4.e = {{(EW-E){1'b0}}, st3.ex} - EW'(lz);
        end
    end

    // S5: round, range check, pack
    logic          up, nx;
    logic [M+1:0]  mant;
    logic [EW-1:0] e5;
    logic [M-1:0]  frac;
    logic [W-1:0]  r5;
    logic [3:0]    f5;

    always_comb begin
        nx   = |st4.n[2:0];
        up   = !st4.c.rtz && st4.n[2] && (st4.n[1] || st4.n[0] || st4.n[3]);
        mant = {1'b0, st4.n[L-1:3]} + {{(M+1){1'b0}}, up};
        e5   = st4.e + {{(EW-1){1'b0}}, mant[M+1]};
        frac = mant[M+1] ? mant[M:1] : mant[M-1:0];
        r5   = {st4.sx, e5[E-1:0], frac};
        f5   = {3'b000, nx};
        if (st4.c.spec) begin
            r5 = st4.c.sres;
            f5 = {st4.c.snv, 3'b000};
        end else if (st4.zero) begin
            r5 = '0;
            f5 = '0;
        end else if (e5[EW-1] || e5 == '0) begin
            r5 = {st4.sx, {(W-1){1'b0}}};
            f5 = 4'b0011;
        end else if (e5 >= EMAX) begin
            r5 = st4.c.rtz ? {st4.sx, {(E-1){1'b1}}, 1'b0, {M{1'b1}}}
                           : {st4.sx, {E{1'b1}}, {M{1'b0}}};
            f5 = 4'b0101;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            v4        <= 1'b0;
            out_valid <= 1'b0;
            R         <= '0;
            flags     <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            v4        <= v3;
            out_valid <= v4;
            if (in_valid) st1 <= n1;
            if (v1) st2 <= n2;
            if (v2) st3 <= n3;
            if (v3) st4 <= n4;
            if (v4) begin
                R       <= r5;
                flags   <= f5;
                out_tag <= st4.c.tag;
            end
        end
    end
endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Directed-vector bench for fp_add_sub_pipe (binary32 defaults).
module tb_fp_add_sub_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        operation_select = 1'b0;
    logic        rnd_mode = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] R;
    logic [3:0]  flags;
    logic [3:0]  out_tag;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_add_sub_pipe dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .operation_select(operation_select),
        .rnd_mode(rnd_mode),
        .in_tag(in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .R(R),
        .flags(flags),
        .out_tag(out_tag)
    );

    task automatic send_get(input logic [31:0] x, input logic [31:0] y,
                            input logic op, input logic rm,
                            input logic [3:0] tg,
                            output logic [31:0] r, output logic [3:0] f,
                            output logic [3:0] ot, output int lat);
        @(negedge clk);
        a = x;
        b = y;
        operation_select = op;
        rnd_mode = rm;
        in_tag = tg;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r = R;
        f = flags;
        ot = out_tag;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_vec++;
        if (R !== 32'h0) begin
            n_err++;
            $display("FAIL reset_R: got %h want 00000000", R);
        end
        n_vec++;
        if (flags !== 4'h0 || out_tag !== 4'h0) begin
            n_err++;
            $display("FAIL reset_flags_tag: got %b/%h want 0000/0", flags, out_tag);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [31:0] r;
        logic [3:0]  f, t;
        int          lat;
        send_get(32'h3F800000, 32'h40000000, 1'b0, 1'b0, 4'hA, r, f, t, lat);
        n_vec++;
        if (lat !== 5) begin
            n_err++;
            $display("FAIL add_latency: got %0d want 5", lat);
        end
        n_vec++;
        if (r !== 32'h40400000) begin
            n_err++;
            $display("FAIL add_R: got %h want 40400000", r);
        end
        n_vec++;
        if (f !== 4'b0000) begin
            n_err++;
            $display("FAIL add_flags: got %b want 0000", f);
        end
        n_vec++;
        if (t !== 4'hA) begin
            n_err++;
            $display("FAIL add_tag: got %h want a", t);
        end
    endtask

    task automatic test_sub_tie();
        logic [31:0] r;
        logic [3:0]  f, t;
        int          lat;
        send_get(32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 4'h3, r, f, t, lat);
        n_vec++;
        if (r !== 32'h00000000 || f !== 4'b0000) begin
            n_err++;
            $display("FAIL sub_cancel: got %h/%b want 00000000/0000", r, f);
        end
        send_get(32'h3F800000, 32'h33800000, 1'b0, 1'b0, 4'h4, r, f, t, lat);
        n_vec++;
        if (r !== 32'h3F800000) begin
            n_err++;
            $display("FAIL tie_R: got %h want 3f800000", r);
        end
        n_vec++;
        if (f !== 4'b0001) begin
            n_err++;
            $display("FAIL tie_flags: got %b want 0001", f);
        end
    endtask

    task automatic test_range();
        logic [31:0] va [3] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00800000};
        logic [31:0] vb [3] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00800001};
        logic        vo [3] = '{1'b0, 1'b0, 1'b1};
        logic        vm [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] er [3] = '{32'h7F800000, 32'h7F7FFFFF, 32'h80000000};
        logic [3:0]  ef [3] = '{4'b0101, 4'b0101, 4'b0011};
        logic [31:0] r;
        logic [3:0]  f, t;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            send_get(va[i], vb[i], vo[i], vm[i], 4'(i), r, f, t, lat);
            n_vec++;
            if (r !== er[i]) begin
                n_err++;
                $display("FAIL range[%0d]_R: got %h want %h", i, r, er[i]);
            end
            n_vec++;
            if (f !== ef[i]) begin
                n_err++;
                $display("FAIL range[%0d]_flags: got %b want %b", i, f, ef[i]);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] va [8] = '{32'h7F800000, 32'h7F800001, 32'h80000000,
                                32'h00000000, 32'h3F800000, 32'hFF800000,
                                32'h3F800000, 32'h7FC00000};
        logic [31:0] vb [8] = '{32'h7F800000, 32'h3F800000, 32'h80000000,
                                32'h3F800000, 32'h00000000, 32'h3F800000,
                                32'h7F800000, 32'h3F800000};
        logic        vo [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] er [8] = '{32'h7FC00000, 32'h7FC00000, 32'h80000000,
                                32'hBF800000, 32'h3F800000, 32'hFF800000,
                                32'hFF800000, 32'h7FC00000};
        logic [3:0]  ef [8] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000,
                                4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic [31:0] r;
        logic [3:0]  f, t;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            send_get(va[i], vb[i], vo[i], 1'b0, 4'(i), r, f, t, lat);
            n_vec++;
            if (r !== er[i]) begin
                n_err++;
                $display("FAIL special[%0d]_R: got %h want %h", i, r, er[i]);
            end
            n_vec++;
            if (f !== ef[i]) begin
                n_err++;
                $display("FAIL special[%0d]_flags: got %b want %b", i, f, ef[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [8] = '{32'h3F800000, 32'h3F800000, 32'h40000000,
                                32'h40400000, 32'h40800000, 32'h40400000,
                                32'h3F800000, 32'h40A00000};
        logic [31:0] tb_ [8] = '{32'h3F800000, 32'h40000000, 32'h40000000,
                                 32'h3F800000, 32'h3F800000, 32'h40000000,
                                 32'h40000000, 32'h40A00000};
        logic        to [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] te [8] = '{32'h40000000, 32'h40400000, 32'h40800000,
                                32'h40800000, 32'h40400000, 32'h3F800000,
                                32'hBF800000, 32'h41200000};
        int          sent = 0;
        int          got = 0;
        int          cyc = 0;
        int          stalls = 0;
        int          extra = 0;
        logic        was_stall = 1'b0;
        logic [31:0] held = '0;
        while (got < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 7 && cyc <= 9);
            if (sent < 8) begin
                in_valid = 1'b1;
                a = ta[sent];
                b = tb_[sent];
                operation_select = to[sent];
                rnd_mode = 1'b0;
                in_tag = 4'(8 + sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                n_vec++;
                if (in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_in_ready: got %b want 0", in_ready);
                end
                if (was_stall) begin
                    n_vec++;
                    if (R !== held) begin
                        n_err++;
                        $display("FAIL stall_R_stable: got %h want %h", R, held);
                    end
                end
                held = R;
                was_stall = 1'b1;
            end else begin
                was_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (R !== te[got]) begin
                    n_err++;
                    $display("FAIL stream[%0d]_R: got %h want %h", got, R, te[got]);
                end
                n_vec++;
                if (out_tag !== 4'(8 + got)) begin
                    n_err++;
                    $display("FAIL stream[%0d]_tag: got %h want %h", got, out_tag, 4'(8 + got));
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) begin
            #1;
            if (out_valid) extra++;
            @(negedge clk);
        end
        n_vec++;
        if (got !== 8) begin
            n_err++;
            $display("FAIL stream_count: got %0d want 8", got);
        end
        n_vec++;
        if (stalls !== 3) begin
            n_err++;
            $display("FAIL stream_stalls: got %0d want 3", stalls);
        end
        n_vec++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL stream_extra: got %0d want 0", extra);
        end
    endtask

    task automatic test_reset_midstream();
        int stale = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 32'h3F800000;
            b = 32'h3F800000;
            operation_select = 1'b0;
            in_tag = 4'(i + 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b1 || R !== 32'h40000000) begin
            n_err++;
            $display("FAIL rst_mid_pre: got %b/%h want 1/40000000", out_valid, R);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        n_vec++;
        if (out_valid !== 1'b0 || R !== 32'h0 || out_tag !== 4'h0) begin
            n_err++;
            $display("FAIL rst_mid_clear: got %b/%h/%h want 0/00000000/0", out_valid, R, out_tag);
        end
        repeat (10) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        n_vec++;
        if (stale !== 0) begin
            n_err++;
            $display("FAIL rst_mid_stale: got %0d want 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_tie();
        test_range();
        test_specials();
        test_back_to_back();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
